reaction_session_ctrl: RTL and testbench
========================================

# reaction_session_ctrl

Sequencer for a multi-round reaction-timer session. It runs one 1 kHz-strobed clock domain and generates a pseudo-random foreperiod before each `go`. For each round it measures the millisecond reaction to `ss`, detects false starts and timeouts, and accumulates best and average times over `ROUNDS` trials. It sits between the board pushbuttons and display logic and replaces ad-hoc FSM and counter wiring with a single scheduled session.

## Interface

Parameters:

- `ROUNDS`, 4: trials per session; must be a power of two, 2..8.
- `CNT_W`, 11: width of all millisecond result fields.
- `MIN_DELAY`, 1000: minimum foreperiod in ms.
- `TIMEOUT`, 2000: reaction limit in ms; also the penalty value. Must be less than 2^CNT_W.
- `COOL_MS`, 500: gap between rounds in ms.

Ports:

- `clk`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `ms_tick`, in, 1: one-`clk` strobe at 1 kHz.
- `start`, in, 1: one-cycle pulse; begins a session.
- `ss`, in, 1: one-cycle debounced button pulse.
- `go`, out, 1: stimulus lamp; high while awaiting the reaction.
- `busy`, out, 1: high from session start until DONE.
- `false_start`, out, 1: one-cycle pulse.
- `timeout`, out, 1: one-cycle pulse.
- `result_valid`, out, 1: one-cycle pulse per completed round.
- `result_ms`, out, CNT_W: last round time; held between pulses.
- `best_ms`, out, CNT_W: minimum of this session's results.
- `avg_ms`, out, CNT_W: session mean; valid while `done`.
- `round_idx`, out, 3: current round, 0-based.
- `done`, out, 1: session complete; held until the next `start`.

## Operation

- **States:** IDLE, ARM, WAIT_RAND, GO, LOG, COOL, DONE.
- **IDLE:**
  - On `start`: clear `sum`, set `best_ms` to all-ones, set `round_idx` to 0, go to ARM.
- **ARM:**
  - Load `delay_cnt` with `MIN_DELAY + lfsr[9:0]` (range 1000..2023 ms at default).
  - Go to WAIT_RAND.
- **WAIT_RAND:**
  - On `ms_tick`, decrement `delay_cnt`.
  - If `ss` arrives: pulse `false_start`, set the result to `TIMEOUT`, go to LOG.
  - Otherwise, when a tick arrives with `delay_cnt` equal to 1: clear `react_cnt`, go to GO.
- **GO:**
  - `go` is high.
  - On `ms_tick`, increment `react_cnt`.
  - If `ss` arrives: the result is the current `react_cnt`, before any same-cycle increment. Go to LOG.
  - If `react_cnt` reaches `TIMEOUT` with no `ss`: pulse `timeout`, set the result to `TIMEOUT`, go to LOG.
- **LOG (one cycle):**
  - Pulse `result_valid` and update `result_ms`.
  - `sum += result`.
  - `best_ms = min(best_ms, result)`.
  - If `round_idx == ROUNDS-1`, go to DONE. Otherwise increment `round_idx` and go to COOL.
- **COOL:** count `COOL_MS` ticks, then go to ARM.
- **DONE:**
  - `avg_ms = sum >> log2(ROUNDS)` (truncating); `done` is high.
  - On `start`: clear `done`, restart exactly as from IDLE.
- **Widths:** `sum` is `CNT_W + log2(ROUNDS)` bits wide and never overflows. `best_ms` stays all-ones only if no round has been logged.
- **Ignored inputs:**
  - `ss` is ignored in IDLE, ARM, LOG, COOL and DONE.
  - `start` is ignored while `busy`.
- **Simultaneous events:**
  - `ss` in the same cycle as foreperiod expiry counts as a false start.
  - `ss` in the same cycle as the `TIMEOUT` boundary counts as a valid reaction equal to `TIMEOUT`, with no `timeout` pulse.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11, seed 0xACE1. It advances every `clk` regardless of state, so the foreperiod depends on when the user presses `start`.

## Timing

- **Outputs:** all registered; each changes one `clk` after the causing event.
- **`go`:** rises on the `clk` after the expiring `ms_tick`. Falls on the `clk` after `ss` or after the timeout tick.
- **LOG placement:** `result_valid` is high for exactly one cycle, the cycle after the GO/WAIT_RAND exit. `best_ms` and `sum` update in that same cycle.
- **DONE latency:** `done` and a valid `avg_ms` appear 1 `clk` after the final LOG cycle.
- **Reset (`reset` low at a `clk` edge)**, from any state, including mid-round:
  - State goes to IDLE.
  - `go`, `busy`, `done` and all pulses go to 0.
  - `result_ms`, `avg_ms` and `round_idx` go to 0.
  - `best_ms` goes to all-ones.
  - LFSR returns to its seed.

## Structure

- **Package `reaction_pkg`:**
  - State enum `session_state_t`.
  - LFSR seed and tap constants.
  - Default `MIN_DELAY`, `TIMEOUT` and `COOL_MS` values.
- **Sub-module `reaction_lfsr`:** 16-bit LFSR with synchronous active-low reset and free-running enable.
- **Top module:** FSM, `delay_cnt`, `react_cnt` and `cool_cnt`, and the statistics registers.
- **Bench timing:** use a `ms_tick` every 4 `clk` to shorten simulation.

## Test plan

- **Clean session:**
  - Stimulus: `ROUNDS`=4; respond 150, 200, 250, 300 ticks after `go`.
  - Response:
    - `result_valid` pulses 4 times.
    - `best_ms`=150 and `avg_ms`=225.
    - `done`=1 and `busy`=0.
- **False start:**
  - Stimulus: `ss` 10 ticks into WAIT_RAND of round 0.
  - Response:
    - `false_start` pulses for one cycle.
    - `result_ms`=2000 and `go` never rises.
    - `round_idx` goes to 1 after LOG.
- **Timeout:**
  - Stimulus: no `ss` after `go`.
  - Response: `timeout` pulses after exactly 2000 ticks, and `result_ms`=2000.
- **Boundary coincidence:**
  - Stimulus: `ss` on the same cycle as the expiring tick.
  - Response: false start is reported and `go` stays 0.
  - Stimulus: `ss` on the 2000th GO tick.
  - Response: `result_ms`=2000 with no `timeout` pulse.
- **Reset mid-round:**
  - Stimulus: `reset` low for one cycle while `go`=1 in round 2.
  - Response:
    - Next cycle all outputs are at reset values and the state is IDLE.
    - A subsequent `start` begins at `round_idx`=0.
- **Ignored inputs:**
  - Stimulus: `start` while `busy`.
  - Response: no effect.
  - Stimulus: `ss` in COOL.
  - Response: no result and no pulse.
  - Stimulus: `start` in DONE.
  - Response: clears `done` and re-arms the session.

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding, LFSR constants and timing defaults for the reaction session.
package reaction_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_RAND, GO, LOG, COOL, DONE} session_state_t;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam int          DEF_MIN_DELAY = 1000;
  localparam int          DEF_TIMEOUT   = 2000;
  localparam int          DEF_COOL_MS   = 500;
endpackage

// File: rtl/reaction_session_lfsr.sv
// reaction_lfsr: free-running 16-bit Fibonacci LFSR supplying foreperiod randomness.
module reaction_lfsr
  import reaction_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output logic [9:0] rnd_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else if (en_i) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end
  assign rnd_o = lfsr_q[9:0];
endmodule

// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl: multi-round reaction-timer sequencer with random foreperiod, timeout and best/average stats.
module reaction_session_ctrl
  import reaction_pkg::*;
#(
  parameter int ROUNDS    = 4,
  parameter int CNT_W     = 11,
  parameter int MIN_DELAY = DEF_MIN_DELAY,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int COOL_MS   = DEF_COOL_MS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ms_tick,
  input  logic             start,
  input  logic             ss,
  output logic             go,
  output logic             busy,
  output logic             false_start,
  output logic             timeout,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_ms,
  output logic [CNT_W-1:0] best_ms,
  output logic [CNT_W-1:0] avg_ms,
  output logic [2:0]       round_idx,
  output logic             done
);
  localparam int LG    = $clog2(ROUNDS);
  localparam int SUM_W = CNT_W + LG;
  localparam int DLY_W = 16;
  session_state_t   state_q, state_d;
  logic [DLY_W-1:0] delay_q, delay_d, cool_q, cool_d;
  logic [CNT_W-1:0] react_q, react_d, best_q, best_d, result_q, result_d, avg_q, avg_d, res;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [2:0]       round_q, round_d;
  logic [9:0]       rnd;
  logic             go_q, busy_q, done_q, fs_q, fs_d, to_q, to_d, rv_q, log_en;
  reaction_lfsr u_lfsr (.clk(clk), .reset(reset), .en_i(1'b1), .rnd_o(rnd));
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    react_d  = react_q;
    cool_d   = cool_q;
    sum_d    = sum_q;
    best_d   = best_q;
    result_d = result_q;
    avg_d    = avg_q;
    round_d  = round_q;
    fs_d     = 1'b0;
    to_d     = 1'b0;
    log_en   = 1'b0;
    res      = '0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = ARM;
        sum_d   = '0;
        best_d  = '1;
        round_d = '0;
      end
      ARM: begin
        delay_d = DLY_W'(MIN_DELAY) + DLY_W'(rnd);
        state_d = WAIT_RAND;
      end
      WAIT_RAND: begin
        delay_d = ms_tick ? delay_q - DLY_W'(1) : delay_q;
        if (ss) begin
          fs_d   = 1'b1;
          log_en = 1'b1;
          res    = CNT_W'(TIMEOUT);
        end else if (ms_tick && delay_q == DLY_W'(1)) begin
          react_d = '0;
          state_d = GO;
        end
      end
      GO: begin
        react_d = ms_tick ? react_q + CNT_W'(1) : react_q;
        if (ss) begin
          log_en = 1'b1;
          res    = react_q;
        end else if (react_q == CNT_W'(TIMEOUT)) begin
          to_d   = 1'b1;
          log_en = 1'b1;
          res    = CNT_W'(TIMEOUT);
        end
      end
      LOG: if (round_q == 3'(ROUNDS - 1)) begin
        state_d = DONE;
        avg_d   = CNT_W'(sum_q >> LG);
      end else begin
        round_d = round_q + 3'd1;
        cool_d  = '0;
        state_d = COOL;
      end
      COOL: if (ms_tick) begin
        cool_d  = cool_q + DLY_W'(1);
        state_d = cool_q == DLY_W'(COOL_MS - 1) ? ARM : COOL;
      end
      default: state_d = IDLE;
    endcase
    if (log_en) begin
      state_d  = LOG;
      result_d = res;
      sum_d    = sum_q + SUM_W'(res);
      best_d   = res < best_q ? res : best_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      delay_q  <= '0;
      react_q  <= '0;
      cool_q   <= '0;
      sum_q    <= '0;
      best_q   <= '1;
      result_q <= '0;
      avg_q    <= '0;
      round_q  <= '0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fs_q     <= 1'b0;
      to_q     <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      react_q  <= react_d;
      cool_q   <= cool_d;
      sum_q    <= sum_d;
      best_q   <= best_d;
      result_q <= result_d;
      avg_q    <= avg_d;
      round_q  <= round_d;
      go_q     <= state_d == GO;
      busy_q   <= !(state_d inside {IDLE, DONE});
      done_q   <= state_d == DONE;
      fs_q     <= fs_d;
      to_q     <= to_d;
      rv_q     <= log_en;
    end
  end
  assign go           = go_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;
  assign result_valid = rv_q;
  assign result_ms    = result_q;
  assign best_ms      = best_q;
  assign avg_ms       = avg_q;
  assign round_idx    = round_q;
endmodule

// File: tb/tb_reaction_session_ctrl.sv
// tb_reaction_session_ctrl: directed sessions checked every cycle against a behavioural session model.
module tb_reaction_session_ctrl;
  localparam int NR = 4, CW = 11, MIND = 20, TO = 2000, COOL = 20, ONES = 2047;
  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_GO = 3, P_LOG = 4, P_COOL = 5, P_DONE = 6;
  logic clk = 0, reset, ms_tick, start, ss;
  logic go, busy, false_start, timeout, result_valid, done;
  logic [CW-1:0] result_ms, best_ms, avg_ms;
  logic [2:0] round_idx;
  int checks = 0, errors = 0, cmp_en = 0, kt = 0;
  int go_seen = 0, to_cnt = 0, rv_cnt = 0, t, n, base;
  int m_ph = P_IDLE, m_left, m_el, m_cl, m_go, m_busy, m_done, m_fs, m_to, m_rv;
  int m_result, m_best = ONES, m_avg, m_round, got, val, s;
  int m_res[$];
  logic [15:0] lf;
  reaction_session_ctrl #(.ROUNDS(NR), .CNT_W(CW), .MIN_DELAY(MIND), .TIMEOUT(TO), .COOL_MS(COOL)) dut (
    .clk(clk), .reset(reset), .ms_tick(ms_tick), .start(start), .ss(ss), .go(go), .busy(busy),
    .false_start(false_start), .timeout(timeout), .result_valid(result_valid), .result_ms(result_ms),
    .best_ms(best_ms), .avg_ms(avg_ms), .round_idx(round_idx), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic wait_for(input int w, input string nm);
    int k = 0;
    while (!(w == 0 ? go : w == 1 ? result_valid : w == 2 ? false_start : done) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) chk({nm, "_wait_expired"}, 1, 0);
  endtask
  task automatic respond(input int cnt);
    int k = 0;
    while (k < cnt) begin
      @(posedge clk);
      if (ms_tick) k++;
    end
    @(negedge clk);
    ss = 1;
    @(negedge clk);
    ss = 0;
  endtask
  initial begin
    ms_tick = 0;
    forever begin
      @(posedge clk);
      #1;
      kt++;
      ms_tick = (kt % 4 == 0);
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (go) go_seen = 1;
    if (timeout) to_cnt++;
    if (result_valid) rv_cnt++;
  end
  initial forever begin
    @(posedge clk);
    m_fs = 0;
    m_to = 0;
    m_rv = 0;
    if (!reset) begin
      m_ph = P_IDLE;
      lf = 16'hACE1;
      m_res.delete();
      m_result = 0;
      m_avg = 0;
      m_round = 0;
    end else begin
      got = 0;
      val = 0;
      case (m_ph)
        P_IDLE, P_DONE: if (start) begin
          m_ph = P_ARM;
          m_res.delete();
          m_round = 0;
        end
        P_ARM: begin
          m_left = MIND + (lf % 1024);
          m_ph = P_WAIT;
        end
        P_WAIT: if (ss) begin
          m_fs = 1; got = 1; val = TO;
        end else if (ms_tick) begin
          m_left--;
          if (m_left == 0) begin m_ph = P_GO; m_el = 0; end
        end
        P_GO: if (ss) begin
          got = 1; val = m_el;
        end else if (m_el == TO) begin
          m_to = 1; got = 1; val = TO;
        end else if (ms_tick) m_el++;
        P_LOG: if (m_round == NR - 1) begin
          s = 0;
          foreach (m_res[i]) s += m_res[i];
          m_avg = s / NR;
          m_ph = P_DONE;
        end else begin
          m_round++;
          m_cl = 0;
          m_ph = P_COOL;
        end
        P_COOL: if (ms_tick) begin
          m_cl++;
          if (m_cl == COOL) m_ph = P_ARM;
        end
        default: m_ph = P_IDLE;
      endcase
      if (got) begin
        m_res.push_back(val);
        m_result = val;
        m_rv = 1;
        m_ph = P_LOG;
      end
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
    m_go = (m_ph == P_GO);
    m_busy = (m_ph != P_IDLE && m_ph != P_DONE);
    m_done = (m_ph == P_DONE);
    m_best = ONES;
    foreach (m_res[i]) if (m_res[i] < m_best) m_best = m_res[i];
  end
  initial forever begin
    @(negedge clk);
    if (cmp_en != 0) begin
      chk("go", int'(go), m_go);
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
      chk("false_start", int'(false_start), m_fs);
      chk("timeout", int'(timeout), m_to);
      chk("result_valid", int'(result_valid), m_rv);
      chk("result_ms", int'(result_ms), m_result);
      chk("best_ms", int'(best_ms), m_best);
      chk("avg_ms", int'(avg_ms), m_avg);
      chk("round_idx", int'(round_idx), m_round);
    end
  end
  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 0; start = 0; ss = 0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("rst_best", int'(best_ms), ONES);
    chk("rst_busy", int'(busy), 0);
    reset = 1;
    repeat (2) @(negedge clk);
    rv_cnt = 0;
    start = 1; @(negedge clk); start = 0;
    for (int r = 0; r < NR; r++) begin
      wait_for(0, "a_go");
      respond(150 + 50 * r);
      chk("a_rv", int'(result_valid), 1);
      chk("a_result", int'(result_ms), 150 + 50 * r);
      if (r == 0) begin
        @(negedge clk); ss = 1;
        @(negedge clk); ss = 0; start = 1;
        @(negedge clk); start = 0;
        chk("cool_ss_rv", int'(result_valid), 0);
        chk("cool_ss_fs", int'(false_start), 0);
        chk("busy_start_round", int'(round_idx), 1);
        chk("busy_start_busy", int'(busy), 1);
      end
    end
    wait_for(3, "a_done");
    chk("a_best", int'(best_ms), 150);
    chk("a_avg", int'(avg_ms), 225);
    chk("a_done", int'(done), 1);
    chk("a_busy", int'(busy), 0);
    chk("a_rv_count", rv_cnt, 4);
    go_seen = 0;
    start = 1; @(negedge clk); start = 0;
    chk("restart_done", int'(done), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_round", int'(round_idx), 0);
    t = 0;
    while (t < 10) begin @(posedge clk); if (ms_tick) t++; end
    @(negedge clk); ss = 1;
    @(negedge clk); ss = 0;
    chk("fs_pulse", int'(false_start), 1);
    chk("fs_result", int'(result_ms), TO);
    chk("fs_go_seen", go_seen, 0);
    @(negedge clk);
    chk("fs_pulse_len", int'(false_start), 0);
    chk("fs_round", int'(round_idx), 1);
    wait_for(0, "to_go");
    t = 0; n = 0;
    do begin
      @(posedge clk);
      if (ms_tick) t++;
      #1;
      n++;
    end while (!timeout && n < 20000);
    chk("to_ticks", t, TO);
    chk("to_result", int'(result_ms), TO);
    @(negedge clk);
    base = to_cnt;
    wait_for(0, "bnd_go");
    respond(TO);
    chk("bnd_result", int'(result_ms), TO);
    chk("bnd_rv", int'(result_valid), 1);
    chk("bnd_timeout", to_cnt - base, 0);
    go_seen = 0; n = 0;
    while (!(m_ph == P_WAIT && m_left == 1 && ms_tick) && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk("coin_wait_expired", 1, 0);
    ss = 1; @(negedge clk); ss = 0;
    chk("coin_fs", int'(false_start), 1);
    chk("coin_result", int'(result_ms), TO);
    wait_for(3, "b_done");
    chk("coin_go_seen", go_seen, 0);
    chk("b_best", int'(best_ms), TO);
    chk("b_avg", int'(avg_ms), TO);
    start = 1; @(negedge clk); start = 0;
    for (int r = 0; r < 2; r++) begin
      wait_for(0, "c_go");
      respond(40 + 20 * r);
    end
    wait_for(0, "c_go2");
    chk("c_round_before_rst", int'(round_idx), 2);
    reset = 0; @(negedge clk); reset = 1;
    chk("rst_go", int'(go), 0);
    chk("rst_busy2", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pulses", int'(false_start) + int'(timeout) + int'(result_valid), 0);
    chk("rst_result", int'(result_ms), 0);
    chk("rst_avg", int'(avg_ms), 0);
    chk("rst_round", int'(round_idx), 0);
    chk("rst_best2", int'(best_ms), ONES);
    repeat (8) @(negedge clk);
    chk("rst_idle", int'(busy), 0);
    rv_cnt = 0;
    start = 1; @(negedge clk); start = 0;
    chk("c_round0", int'(round_idx), 0);
    chk("c_busy", int'(busy), 1);
    for (int r = 0; r < NR; r++) begin
      wait_for(0, "d_go");
      respond(70 + 10 * r);
    end
    wait_for(3, "d_done");
    chk("d_best", int'(best_ms), 70);
    chk("d_avg", int'(avg_ms), 85);
    chk("d_rv_count", rv_cnt, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
